// File: rtl/time_pkg.sv
// Shared BCD time-of-day types, limits and digit helpers for the Temporal group.
package time_pkg;

    localparam logic [7:0] MAX_SEC    = 8'h59;
    localparam logic [7:0] MAX_MIN    = 8'h59;
    localparam logic [7:0] MAX_HOUR24 = 8'h23;
    localparam logic [7:0] NOON       = 8'h12;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic [7:0] sec;
    } hms_t;

    // Returns {carry, next}; wraps to 00 with carry once the field reaches max.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) begin
            return {1'b1, 8'h00};
        end else if (v[3:0] == 4'd9) begin
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        end else begin
            return {1'b0, v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    function automatic logic [7:0] hour_to12(input logic [7:0] h);
        logic [3:0] u;
        u = h[3:0];
        if (h == 8'h00) begin
            return NOON;
        end else if (h <= NOON) begin
            return h;
        end else if (h[7:4] == 4'd1) begin
            return {4'd0, u - 4'd2};
        end else if (u < 4'd2) begin
            return {4'd0, u + 4'd8};
        end else begin
            return {4'd1, u - 4'd2};
        end
    endfunction

    function automatic logic [7:0] hour_to24(input logic [7:0] h, input logic pm);
        logic [3:0] u;
        u = h[3:0];
        if (h == NOON) begin
            return pm ? NOON : 8'h00;
        end else if (!pm) begin
            return h;
        end else if (h[7:4] == 4'd1) begin
            return {4'd2, u + 4'd2};
        end else if (u < 4'd8) begin
            return {4'd1, u + 4'd2};
        end else begin
            return {4'd2, u - 4'd8};
        end
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter; tick strobes combinationally on the wrapping cycle.
module tick_divider #(
    parameter int unsigned DIV   = 10,
    parameter int unsigned DIV_W = 4
) (
    input  logic clk,
    input  logic res,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        tick      = en && (div_cnt_q == DIV_W'(DIV - 1));
        div_cnt_d = div_cnt_q;
        if (clr || tick) begin
            div_cnt_d = '0;
        end else if (en) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/hms_counter.sv
// BCD hours/minutes/seconds counter with 12h/24h display, checked load and day carry.
module hms_counter
    import time_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 24000000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned DIV_W   = $clog2(CLK_HZ / TICK_HZ)
) (
    input  logic       clk,
    input  logic       res,
    input  logic       en,
    input  logic       mode12,
    input  logic       set_valid,
    input  logic [7:0] set_hour,
    input  logic       set_pm,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    output logic       set_err,
    output logic       tick,
    output logic       day_carry,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       pm
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    hms_t time_q, time_d, load_val, adv_val;
    logic tick_q, tick_d, carry_q, carry_d, err_q, err_d;
    logic strobe, load_ok, hour_ok;
    logic [8:0] sec_inc, min_inc, hour_inc;

    tick_divider #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_div (
        .clk  (clk),
        .res  (res),
        .en   (en),
        .clr  (set_valid && load_ok),
        .tick (strobe)
    );

    always_comb begin
        sec_inc  = bcd_inc(time_q.sec, MAX_SEC);
        min_inc  = bcd_inc(time_q.min, MAX_MIN);
        hour_inc = bcd_inc(time_q.hour, MAX_HOUR24);

        adv_val.sec  = sec_inc[7:0];
        adv_val.min  = sec_inc[8] ? min_inc[7:0] : time_q.min;
        adv_val.hour = (sec_inc[8] && min_inc[8]) ? hour_inc[7:0] : time_q.hour;

        // 12h hour 00 is not a legal clock face value.
        hour_ok = mode12 ? (bcd_ok(set_hour, NOON) && set_hour != 8'h00)
                         : bcd_ok(set_hour, MAX_HOUR24);
        load_ok = hour_ok && bcd_ok(set_min, MAX_MIN) && bcd_ok(set_sec, MAX_SEC);
        load_val.hour = mode12 ? hour_to24(set_hour, set_pm) : set_hour;
        load_val.min  = set_min;
        load_val.sec  = set_sec;

        time_d  = time_q;
        tick_d  = 1'b0;
        carry_d = 1'b0;
        err_d   = 1'b0;
        if (set_valid && load_ok) begin
            time_d = load_val;
        end else begin
            err_d = set_valid;
            if (strobe) begin
                time_d  = adv_val;
                tick_d  = 1'b1;
                carry_d = sec_inc[8] && min_inc[8] && hour_inc[8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            time_q  <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            time_q  <= time_d;
            tick_q  <= tick_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign tick      = tick_q;
    assign day_carry = carry_q;
    assign set_err   = err_q;
    assign min_bcd   = time_q.min;
    assign sec_bcd   = time_q.sec;
    assign hour_bcd  = mode12 ? hour_to12(time_q.hour) : time_q.hour;
    assign pm        = (time_q.hour >= NOON);

endmodule

// File: tb/tb_hms_counter.sv
// Directed bench for hms_counter at CLK_HZ=10, TICK_HZ=1 (one tick per ten clocks).
module tb_hms_counter;

    logic       clk = 1'b0;
    logic       res, en, mode12, set_valid, set_pm;
    logic [7:0] set_hour, set_min, set_sec;
    logic       set_err, tick, day_carry, pm;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;

    int checks = 0;
    int errors = 0;

    hms_counter #(
        .CLK_HZ  (10),
        .TICK_HZ (1)
    ) dut (
        .clk       (clk),
        .res       (res),
        .en        (en),
        .mode12    (mode12),
        .set_valid (set_valid),
        .set_hour  (set_hour),
        .set_pm    (set_pm),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .set_err   (set_err),
        .tick      (tick),
        .day_carry (day_carry),
        .hour_bcd  (hour_bcd),
        .min_bcd   (min_bcd),
        .sec_bcd   (sec_bcd),
        .pm        (pm)
    );

    always #5 clk = ~clk;

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s);
        check({tag, ".hour"}, {24'd0, hour_bcd}, {24'd0, h});
        check({tag, ".min"}, {24'd0, min_bcd}, {24'd0, m});
        check({tag, ".sec"}, {24'd0, sec_bcd}, {24'd0, s});
    endtask

    task automatic load(input logic [7:0] h, input logic p, input logic [7:0] m,
                        input logic [7:0] s);
        set_valid = 1'b1;
        set_hour  = h;
        set_pm    = p;
        set_min   = m;
        set_sec   = s;
        run(1);
        set_valid = 1'b0;
    endtask

    initial begin
        int ticks_seen;
        res = 1'b1; en = 1'b0; mode12 = 1'b0; set_valid = 1'b0;
        set_hour = 8'h00; set_pm = 1'b0; set_min = 8'h00; set_sec = 8'h00;
        run(2);
        check_time("reset", 8'h00, 8'h00, 8'h00);
        check("reset.tick", {31'd0, tick}, 32'd0);
        check("reset.err", {31'd0, set_err}, 32'd0);
        check("reset.carry", {31'd0, day_carry}, 32'd0);
        check("reset.pm", {31'd0, pm}, 32'd0);

        // 1: basic counting
        res = 1'b0; en = 1'b1;
        run(9);
        check("t1.notick9", {31'd0, tick}, 32'd0);
        check("t1.sec9", {24'd0, sec_bcd}, 32'h00);
        run(1);
        check("t1.tick10", {31'd0, tick}, 32'd1);
        check_time("t1.c10", 8'h00, 8'h00, 8'h01);
        run(1);
        check("t1.tick11", {31'd0, tick}, 32'd0);
        run(9);
        check("t1.tick20", {31'd0, tick}, 32'd1);
        check("t1.sec20", {24'd0, sec_bcd}, 32'h02);
        run(5);

        // 2: day rollover in 24h mode
        load(8'h23, 1'b0, 8'h59, 8'h58);
        check_time("t2.load", 8'h23, 8'h59, 8'h58);
        check("t2.loadtick", {31'd0, tick}, 32'd0);
        run(10);
        check_time("t2.59", 8'h23, 8'h59, 8'h59);
        check("t2.nocarry", {31'd0, day_carry}, 32'd0);
        check("t2.pm", {31'd0, pm}, 32'd1);
        run(10);
        check_time("t2.wrap", 8'h00, 8'h00, 8'h00);
        check("t2.tick", {31'd0, tick}, 32'd1);
        check("t2.carry", {31'd0, day_carry}, 32'd1);
        run(1);
        check("t2.carry1", {31'd0, day_carry}, 32'd0);
        check("t2.tick1", {31'd0, tick}, 32'd0);
        run(9);
        check("t2.tick2", {31'd0, tick}, 32'd1);

        // 3: 12h mode
        mode12 = 1'b1;
        #1;
        check("t3.disp12", {24'd0, hour_bcd}, 32'h12);
        load(8'h12, 1'b0, 8'h59, 8'h59);
        check_time("t3.load", 8'h12, 8'h59, 8'h59);
        check("t3.pm0", {31'd0, pm}, 32'd0);
        run(10);
        check_time("t3.adv", 8'h01, 8'h00, 8'h00);
        check("t3.pm1", {31'd0, pm}, 32'd0);
        mode12 = 1'b0;
        #1;
        check("t3.disp24", {24'd0, hour_bcd}, 32'h01);
        mode12 = 1'b1;
        load(8'h11, 1'b1, 8'h59, 8'h59);
        check_time("t3.load2", 8'h11, 8'h59, 8'h59);
        check("t3.pm2", {31'd0, pm}, 32'd1);
        mode12 = 1'b0;
        #1;
        check("t3.int23", {24'd0, hour_bcd}, 32'h23);
        mode12 = 1'b1;
        run(10);
        check_time("t3.mid", 8'h12, 8'h00, 8'h00);
        check("t3.pm3", {31'd0, pm}, 32'd0);
        check("t3.carry", {31'd0, day_carry}, 32'd1);
        check("t3.tick", {31'd0, tick}, 32'd1);

        // 4: rejected loads
        load(8'h05, 1'b0, 8'h60, 8'h10);
        check("t4.err_min", {31'd0, set_err}, 32'd1);
        check_time("t4.keep1", 8'h12, 8'h00, 8'h00);
        run(1);
        check("t4.errclr1", {31'd0, set_err}, 32'd0);
        load(8'h05, 1'b0, 8'h10, 8'h5A);
        check("t4.err_sec", {31'd0, set_err}, 32'd1);
        run(1);
        check("t4.errclr2", {31'd0, set_err}, 32'd0);
        load(8'h00, 1'b0, 8'h10, 8'h10);
        check("t4.err_hour", {31'd0, set_err}, 32'd1);
        run(5);
        check("t4.tick", {31'd0, tick}, 32'd1);
        check_time("t4.time", 8'h12, 8'h00, 8'h01);
        check("t4.errend", {31'd0, set_err}, 32'd0);

        // 5: enable freeze mid-divide
        run(4);
        en = 1'b0;
        ticks_seen = 0;
        for (int i = 0; i < 30; i++) begin
            run(1);
            if (tick) ticks_seen++;
        end
        check("t5.noticks", ticks_seen, 0);
        check("t5.frozen", {24'd0, sec_bcd}, 32'h01);
        en = 1'b1;
        run(5);
        check("t5.early", {31'd0, tick}, 32'd0);
        run(1);
        check("t5.tick", {31'd0, tick}, 32'd1);
        check("t5.sec", {24'd0, sec_bcd}, 32'h02);

        // 6: load on the wrap cycle, then mid-count reset
        mode12 = 1'b0;
        run(9);
        check("t6.pre", {31'd0, tick}, 32'd0);
        load(8'h10, 1'b0, 8'h20, 8'h30);
        check("t6.losttick", {31'd0, tick}, 32'd0);
        check_time("t6.load", 8'h10, 8'h20, 8'h30);
        run(9);
        check("t6.early", {31'd0, tick}, 32'd0);
        run(1);
        check("t6.tick", {31'd0, tick}, 32'd1);
        check("t6.sec", {24'd0, sec_bcd}, 32'h31);
        run(3);
        res = 1'b1;
        run(1);
        check_time("t6.reset", 8'h00, 8'h00, 8'h00);
        check("t6.rtick", {31'd0, tick}, 32'd0);
        check("t6.rpm", {31'd0, pm}, 32'd0);
        res = 1'b0;
        mode12 = 1'b1;
        #1;
        check("t6.r12", {24'd0, hour_bcd}, 32'h12);
        run(9);
        check("t6.rearly", {31'd0, tick}, 32'd0);
        run(1);
        check("t6.rtick10", {31'd0, tick}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hms_counter.md
Name: hms_counter

Overview:
- Parametrised successor to the single-digit seconds counter.
- Divides `clk` down to a programmable tick rate and keeps a BCD time-of-day: seconds, minutes and hours.
- Supports runtime 12h/24h display mode, synchronous time load with range checking, count enable, and a day-rollover carry.
- Feeds the display/scan logic and any alarm comparator in the Temporal group.

Parameters:
- CLK_HZ, 24000000, input clock frequency in Hz.
- TICK_HZ, 1, time-advance rate in Hz. DIV = CLK_HZ/TICK_HZ; CLK_HZ must be an integer multiple of TICK_HZ and DIV must be ≥ 2.
- DIV_W, $clog2(CLK_HZ/TICK_HZ), divider counter width.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  reset, synchronous, active-high (single clock domain, no async reset anywhere).
- en  in  1  count enable; 0 freezes both the divider and the time.
- mode12  in  1  display mode: 1 = 12h, 0 = 24h. Display only; internal storage is always 24h.
- set_valid  in  1  one-cycle load request.
- set_hour  in  8  BCD hour: 00..23 in 24h mode, 01..12 in 12h mode.
- set_pm  in  1  PM flag for the load; used only when mode12 = 1.
- set_min  in  8  BCD minutes, 00..59.
- set_sec  in  8  BCD seconds, 00..59.
- set_err  out  1  one-cycle pulse: the load was rejected.
- tick  out  1  one-cycle pulse on every time advance.
- day_carry  out  1  one-cycle pulse on rollover to 00:00:00 (internal).
- hour_bcd  out  8  displayed hour, BCD.
- min_bcd  out  8  minutes, BCD.
- sec_bcd  out  8  seconds, BCD.
- pm  out  1  1 when internal hour ≥ 12, regardless of mode.

Behaviour:
- Reset (`res` = 1 at an edge):
  - div_cnt = 0; time = 00:00:00; tick = set_err = day_carry = 0.
  - Displayed outputs: hour_bcd = 8'h00 in 24h mode, 8'h12 in 12h mode; pm = 0.
  - `res` has priority over everything; a mid-count reset discards partial divider progress.
- Divider:
  - While en = 1, div_cnt counts 0..DIV-1 and wraps.
  - On the edge where div_cnt == DIV-1 and en = 1: div_cnt <= 0, tick <= 1, and time advances on that same edge. tick is high in exactly the cycle the new time is visible.
  - Otherwise tick <= 0. With en = 0, div_cnt holds its value and no tick is produced.
- Advance (pure BCD arithmetic, no binary intermediate):
  - sec units 9 -> 0 with carry into sec tens; sec 59 -> 00 with carry into minutes.
  - min 59 -> 00 with carry into hours.
  - hour 23 -> 00 with day_carry <= 1 for one cycle, coincident with tick.
  - hour 09 -> 10 and hour 19 -> 20 roll the tens digit correctly.
- Display mapping (combinational from the registers, zero latency, so a mode change takes effect immediately):
  - 24h: hour_bcd = internal hour.
  - 12h: internal 00 -> 12, 01..12 unchanged, 13..23 -> h-12 in BCD.
  - pm = (internal hour ≥ 12).
- Load:
  - Validated in the cycle set_valid = 1.
  - Valid when every BCD nibble ≤ 9, sec < 60, min < 60, and hour is 00..23 (24h) or 01..12 (12h).
  - 12h to internal conversion: 12 AM -> 00; 12 PM -> 12; other PM hours -> h+12.
  - Valid load: the time registers take the value on the next edge, div_cnt <= 0, tick and day_carry are forced 0 that edge. The load has priority over a coincident tick, and the tick is lost.
  - Invalid load: time and divider are unchanged and continue normally; set_err <= 1 for one cycle.
  - Load works regardless of en.

Decomposition:
- Package time_pkg holds:
  - BCD digit constants: MAX_SEC = 8'h59, MAX_MIN = 8'h59, MAX_HOUR24 = 8'h23, NOON = 8'h12.
  - A 24-bit packed time type {hour, min, sec}.
  - Functions: BCD increment-with-carry for one 2-digit field; 12h<->24h hour conversion; BCD range check.
- One sub-module, tick_divider:
  - Ports: clk, res, en, clr, tick.
  - Parameterised by DIV; owns div_cnt.
  - hms_counter drives clr on a valid load.

Test Plan (CLK_HZ=10, TICK_HZ=1, so DIV=10):
1. Release `res`, en = 1, run 25 cycles -> tick pulses at cycles 10 and 20; sec_bcd = 8'h01 then 8'h02; hour_bcd = 8'h00.
2. Load 23:59:58 (24h), run 20 cycles -> 23:59:59, then 00:00:00 with day_carry and tick high in the same single cycle.
3. mode12 = 1; load hour 8'h12, set_pm = 0, 8'h59, 8'h59; one tick -> hour_bcd = 8'h01, pm = 0. Then load 11:59:59 with set_pm = 1 and tick -> hour_bcd = 8'h12 AM, pm = 0, day_carry = 1.
4. Load with set_min = 8'h60, then set_sec = 8'h5A, then 12h hour 8'h00 -> set_err pulses once each; time keeps counting uninterrupted.
5. Drop en for 30 cycles in mid-divide (div_cnt = 4) -> no tick and frozen outputs; after re-enable, the next tick comes 6 cycles later.
6. Assert set_valid in the same cycle div_cnt == 9 -> loaded value appears, tick = 0, next tick 10 cycles later. Assert `res` mid-count -> all outputs at reset values on the next edge.
